hilo_divider: RTL and testbench
===============================

HILO_DIVIDER -- requirements
Module: hilo_divider

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1; asynchronous reset, active-high.
REQ-003 SHALL have port start, input, 1; execute-stage divide request (DIV/DIVU decoded from alucontrolE).
REQ-004 SHALL have port signed_div, input, 1; 1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have port a, input, 32; dividend.
REQ-006 SHALL have port b, input, 32; divisor.
REQ-007 SHALL have port cancel, input, 1; execute-stage flush, which aborts the operation in flight.
REQ-008 SHALL have port hilowrite, input, 1; direct HI/LO write (hilowriteE).
REQ-009 SHALL have ports hi_in and lo_in, input, 32 each; data for the direct write.
REQ-010 SHALL have port stall, output, 1; pipeline stall request to the hazard unit.
REQ-011 SHALL have port ready, output, 1; one-cycle completion pulse.
REQ-012 SHALL have ports hi_o and lo_o, output, 32 each; architectural HI (remainder) and LO (quotient).

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE, with a 6-bit iteration counter.
REQ-014 In IDLE with start=1, cancel=0 and b!=0, the block SHALL latch |a| and |b|, latch the quotient sign (a[31]^b[31])&signed_div and the remainder sign a[31]&signed_div, clear the counter, and enter BUSY.
REQ-015 In BUSY, the block SHALL perform one restoring shift-subtract step per cycle (33-bit partial remainder) and move to DONE after exactly 32 steps.
REQ-016 On the edge entering DONE, the block SHALL load lo_o with the sign-corrected quotient and hi_o with the sign-corrected remainder.
REQ-017 The block SHALL spend exactly one cycle in DONE, with ready=1 and stall=0, then return to IDLE.
REQ-018 stall SHALL be combinational: (IDLE & start & ~cancel) | BUSY. Timing: start in cycle 0; stall high in cycles 0..32; ready high in cycle 33; new results visible in cycle 33.
REQ-019 A division with b==0 SHALL go IDLE -> DONE in one cycle, leave hi_o/lo_o unchanged, and pulse ready in cycle 1; stall SHALL be high only in cycle 0.
REQ-020 The block SHALL ignore start while in DONE, because the same instruction is still leaving the execute stage.
REQ-021 cancel=1 in BUSY or DONE SHALL force IDLE on the next edge, with no ready pulse and hi_o/lo_o unchanged; cancel=1 in IDLE SHALL suppress start.
REQ-022 hilowrite=1 in IDLE with start=0 SHALL load hi_o<=hi_in and lo_o<=lo_in on the next edge; in all other states, or when start=1, hilowrite SHALL be ignored.
REQ-023 The signed case 0x80000000 / 0xFFFFFFFF SHALL yield lo_o=0x80000000 and hi_o=0 (wrap-around, no trap).
REQ-024 Inputs a, b and signed_div SHALL be sampled only at acceptance; changes to them during BUSY SHALL have no effect.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, counter 0, hi_o=0, lo_o=0, ready=0 and internal operand registers to 0; stall SHALL then equal start & ~cancel.
REQ-026 rst asserted mid-BUSY SHALL abandon the operation: no ready pulse, and HI/LO SHALL read 0 after release.

Verification
REQ-027 Unsigned: DIVU a=100, b=7 -> stall high cycles 0..32, ready in cycle 33, lo_o=14, hi_o=2.
REQ-028 Signed: DIV a=0xFFFFFFF9 (-7), b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU a=0xFFFFFFFF, b=1 -> lo_o=0xFFFFFFFF, hi_o=0.
REQ-029 Divide by zero: HI/LO preloaded to 0x11111111/0x22222222, DIV b=0 -> ready in cycle 1, HI/LO unchanged, stall high in cycle 0 only.
REQ-030 Cancel: DIVU 100/7, cancel in cycle 10 -> IDLE in cycle 11, stall low, no ready, HI/LO unchanged; a back-to-back start in cycle 11 is accepted.
REQ-031 Direct write: hilowrite with hi_in=0x12345678, lo_in=0x9ABCDEF0 in IDLE -> outputs updated the next cycle; the same write issued during BUSY is ignored.
REQ-032 Reset: rst pulsed asynchronously mid-BUSY (between edges) -> outputs 0 immediately, no ready; overflow case 0x80000000/0xFFFFFFFF signed -> lo_o=0x80000000, hi_o=0.

Source files
------------

// File: rtl/hilo_divider.sv
// ---------------------------------------------------------------------------
// hilo_divider
//
// Multi-cycle divider that owns the architectural HI/LO registers of the
// pipeline. It accepts a DIV/DIVU request from the execute stage. It runs a
// restoring shift-subtract loop, one quotient bit per cycle, and then writes
// the quotient into LO and the remainder into HI. The execute stage can also
// write HI/LO directly (MTHI/MTLO path) while no divide is in flight.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rst         asynchronous reset, active-high
//   start       divide request from the execute stage
//   signed_div  1 = DIV (two's complement), 0 = DIVU
//   a, b        dividend, divisor (sampled only when a request is accepted)
//   cancel      execute-stage flush; aborts the operation in flight
//   hilowrite   direct HI/LO write strobe
//   hi_in/lo_in data for the direct write
//   stall       combinational stall request to the hazard unit
//   ready       one-cycle completion pulse
//   hi_o/lo_o   architectural HI (remainder) and LO (quotient)
//
// State | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting; accepts a divide request or a direct HI/LO write
// BUSY  | 32 restoring iterations, one quotient bit per cycle
// DONE  | one-cycle completion: ready=1, start ignored (same instruction)
// ---------------------------------------------------------------------------
module hilo_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hilowrite,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        stall,
  output logic        ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT       state;
  logic [5:0]  iterCount;
  logic [31:0] divisorMag;
  logic [31:0] quotient;    // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [31:0] partRem;
  logic        quotNeg;
  logic        remNeg;

  logic [32:0] shiftedRem;
  logic [32:0] trialDiff;
  logic        stepFits;
  logic [31:0] nextRem;
  logic [31:0] nextQuot;
  logic [31:0] finalQuot;
  logic [31:0] finalRem;
  logic [31:0] absA;
  logic [31:0] absB;
  logic        accept;

  always_comb begin
    // The partial remainder is always below the divisor, so one shift can
    // carry into bit 32. The trial subtraction therefore runs at 33 bits.
    // Bit 32 of the difference is a clean borrow flag.
    shiftedRem = {1'b0, partRem} << 1;
    shiftedRem[0] = quotient[31];
    trialDiff  = shiftedRem - {1'b0, divisorMag};
    stepFits   = ~trialDiff[32];
    // Whichever value is kept is below the divisor, so 32 bits suffice.
    nextRem    = stepFits ? trialDiff[31:0] : shiftedRem[31:0];
    nextQuot   = {quotient[30:0], stepFits};

    // The quotient is negated when the operand signs differ. The remainder
    // takes the dividend's sign. 0x80000000 / -1 wraps back to 0x80000000.
    finalQuot  = quotNeg ? (32'd0 - nextQuot) : nextQuot;
    finalRem   = remNeg  ? (32'd0 - nextRem)  : nextRem;

    absA       = (signed_div && a[31]) ? (32'd0 - a) : a;
    absB       = (signed_div && b[31]) ? (32'd0 - b) : b;

    accept     = (state == IDLE) && start && !cancel;
    stall      = accept || (state == BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      iterCount  <= 6'd0;
      divisorMag <= 32'd0;
      quotient   <= 32'd0;
      partRem    <= 32'd0;
      quotNeg    <= 1'b0;
      remNeg     <= 1'b0;
      ready      <= 1'b0;
      hi_o       <= 32'd0;
      lo_o       <= 32'd0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (b == 32'd0) begin
              // Divide by zero completes at once and leaves HI/LO alone.
              state <= DONE;
              ready <= 1'b1;
            end else begin
              quotient   <= absA;
              divisorMag <= absB;
              partRem    <= 32'd0;
              quotNeg    <= (a[31] ^ b[31]) & signed_div;
              remNeg     <= a[31] & signed_div;
              iterCount  <= 6'd0;
              state      <= BUSY;
            end
          end else if (hilowrite && !start) begin
            hi_o <= hi_in;
            lo_o <= lo_in;
          end
        end

        BUSY: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            partRem   <= nextRem;
            quotient  <= nextQuot;
            iterCount <= iterCount + 6'd1;
            if (iterCount == 6'd31) begin
              // The 32nd step lands directly in HI/LO, sign-corrected.
              state <= DONE;
              ready <= 1'b1;
              lo_o  <= finalQuot;
              hi_o  <= finalRem;
            end
          end
        end

        DONE: begin
          // The requesting instruction is still in execute here, so its
          // start is ignored. A cancel changes nothing because we leave anyway.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signedDiv;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hilowrite;
  logic [31:0] hiIn;
  logic [31:0] loIn;
  logic        stall;
  logic        ready;
  logic [31:0] hiO;
  logic [31:0] loO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } expT;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eHi;
    logic [31:0] eLo;
  } vecT;

  expT         expQ[$];
  vecT         vecs[10];
  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] modelHi;
  logic [31:0] modelLo;

  hilo_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signedDiv),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .hilowrite (hilowrite),
    .hi_in     (hiIn),
    .lo_in     (loIn),
    .stall     (stall),
    .ready     (ready),
    .hi_o      (hiO),
    .lo_o      (loO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference divide built on the simulator's own unsigned / and %.
  function automatic void refDiv(input logic sd, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] q, output logic [31:0] r);
    logic [32:0] ax, ay, uq, ur;
    ax = {1'b0, x};
    ay = {1'b0, y};
    if (sd && x[31]) ax = 33'h1_0000_0000 - {1'b0, x};
    if (sd && y[31]) ay = 33'h1_0000_0000 - {1'b0, y};
    uq = ax / ay;
    ur = ax % ay;
    q = (sd && (x[31] ^ y[31])) ? (32'd0 - uq[31:0]) : uq[31:0];
    r = (sd && x[31]) ? (32'd0 - ur[31:0]) : ur[31:0];
  endfunction

  // Scoreboard: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    expT e;
    if (ready === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpectedReady", {31'd0, ready}, 32'd0);
      end else begin
        e = expQ.pop_front();
        check("hiAtReady", hiO, e.hi);
        check("loAtReady", loO, e.lo);
        check("stallAtReady", {31'd0, stall}, 32'd0);
      end
    end
  end

  // Issues one divide and measures stall/ready timing relative to cycle 0.
  // hold keeps start high until after ready. hlwCyc issues a direct write in
  // that cycle (-1 = none). sameCycle drives in the current cycle.
  task automatic runOp(input logic sd, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eHi, input logic [31:0] eLo, input int expCyc,
                       input bit hold, input int hlwCyc, input bit sameCycle);
    expT         e;
    int          stallCnt  = 0;
    int          lastStall = -1;
    int          readyCyc  = -1;
    logic [31:0] prevHi, prevLo;
    prevHi = modelHi;
    prevLo = modelLo;
    if (!sameCycle) begin
      @(posedge clk);
      #1;
    end
    signedDiv = sd;
    a         = aa;
    b         = bb;
    start     = 1'b1;
    hilowrite = (hlwCyc == 0);
    hiIn      = 32'hCAFEF00D;
    loIn      = 32'h0BADBEEF;
    e.hi = eHi;
    e.lo = eLo;
    expQ.push_back(e);
    modelHi = eHi;
    modelLo = eLo;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (stall) begin
        stallCnt++;
        lastStall = c;
      end
      if (hlwCyc > 0 && c == hlwCyc + 1) begin
        check("busyWriteHi", hiO, prevHi);
        check("busyWriteLo", loO, prevLo);
      end
      if (ready) begin
        readyCyc = c;
        break;
      end
      @(posedge clk);
      #1;
      if (!hold) begin
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        signedDiv = ~sd;
      end
      hilowrite = (c + 1 == hlwCyc);
    end
    hilowrite = 1'b0;
    check("readyCycle", 32'(readyCyc), 32'(expCyc));
    check("stallCycles", 32'(stallCnt), 32'(expCyc));
    check("lastStallCycle", 32'(lastStall), 32'(expCyc - 1));
    if (hold) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("stallAfterHeldStart", {31'd0, stall}, 32'd0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] q, r, ra, rb;
    logic        rsd;
    int          stallSeen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd2,        32'd14};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[5] = '{1'b1, 32'd100,        32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};
    vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
    vecs[7] = '{1'b0, 32'd5,          32'd10,       32'd5,        32'd0};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[9] = '{1'b1, 32'h7FFFFFFF,   32'h80000000, 32'h7FFFFFFF, 32'd0};

    rst = 1'b1; start = 1'b0; signedDiv = 1'b0; a = '0; b = '0;
    cancel = 1'b0; hilowrite = 1'b0; hiIn = '0; loIn = '0;
    modelHi = '0; modelLo = '0;

    // Reset state, and stall follows start & ~cancel while reset is held.
    #12;
    check("resetHi", hiO, 32'd0);
    check("resetLo", loO, 32'd0);
    check("resetReady", {31'd0, ready}, 32'd0);
    check("resetStall", {31'd0, stall}, 32'd0);
    start = 1'b1;
    #1 check("resetStallStart", {31'd0, stall}, 32'd1);
    cancel = 1'b1;
    #1 check("resetStallCancel", {31'd0, stall}, 32'd0);
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      runOp(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo, 33, 1'b0, -1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rsd = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (i % 2 == 1) ? $urandom : 32'($urandom_range(1, 1000));
      if (rb == 32'd0) rb = 32'd1;
      refDiv(rsd, ra, rb, q, r);
      runOp(rsd, ra, rb, r, q, 33, 1'b0, -1, 1'b0);
    end

    // Direct write in IDLE lands on the following edge.
    @(posedge clk); #1;
    hilowrite = 1'b1; hiIn = 32'h12345678; loIn = 32'h9ABCDEF0;
    @(negedge clk);
    check("directWriteNotYetHi", hiO, modelHi);
    @(posedge clk); #1;
    hilowrite = 1'b0;
    @(negedge clk);
    check("directWriteHi", hiO, 32'h12345678);
    check("directWriteLo", loO, 32'h9ABCDEF0);
    modelHi = 32'h12345678; modelLo = 32'h9ABCDEF0;

    // The same kind of write issued mid-BUSY is ignored.
    runOp(1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 1'b0, 5, 1'b0);

    // Divide by zero with HI/LO preloaded, start held into DONE and a direct
    // write offered alongside start.
    @(posedge clk); #1;
    hilowrite = 1'b1; hiIn = 32'h11111111; loIn = 32'h22222222;
    @(posedge clk); #1;
    hilowrite = 1'b0;
    modelHi = 32'h11111111; modelLo = 32'h22222222;
    runOp(1'b1, 32'h00001234, 32'd0, 32'h11111111, 32'h22222222, 1, 1'b1, 0, 1'b0);
    runOp(1'b0, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1, 1'b0, -1, 1'b0);

    // Start held through BUSY and DONE of a normal divide.
    runOp(1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 33, 1'b1, -1, 1'b0);

    // Cancel in cycle 10, then a back-to-back start in cycle 11.
    @(posedge clk); #1;
    signedDiv = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk);
    check("stallInCancelCycle", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    cancel = 1'b0;
    #1;
    check("stallAfterCancel", {31'd0, stall}, 32'd0);
    check("hiAfterCancel", hiO, modelHi);
    check("loAfterCancel", loO, modelLo);
    runOp(1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 1'b0, -1, 1'b1);

    // Asynchronous reset between edges mid-BUSY.
    @(posedge clk); #1;
    signedDiv = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midResetHi", hiO, 32'd0);
    check("midResetLo", loO, 32'd0);
    check("midResetReady", {31'd0, ready}, 32'd0);
    check("midResetStall", {31'd0, stall}, 32'd0);
    #3 rst = 1'b0;
    modelHi = '0; modelLo = '0;
    stallSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (stall) stallSeen++;
    end
    check("stallAfterReset", 32'(stallSeen), 32'd0);
    check("hiAfterReset", hiO, 32'd0);
    check("loAfterReset", loO, 32'd0);

    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 1'b0, -1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
